// File: rtl/io_seq_checker_pkg.sv
// Shared constants for the IO sequence checker: FSM state encoding and
// compare-mode selectors.
package io_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ORDERED = 1'b0;
  localparam logic MODE_STRICT  = 1'b1;

endpackage

// File: rtl/io_seq_checker_sync2.sv
// Two-flop synchroniser bringing the asynchronous monitored bus into the
// checker clock domain.
module io_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/io_seq_checker.sv
// Watches a synchronised IO bus and checks it steps through a programmed
// table of masked expected values, in ordered or strict mode, with timeout.
module io_seq_checker
  import io_seq_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int TMO_W = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       tbl_we,
  input  logic [$clog2(DEPTH)-1:0]   tbl_addr,
  input  logic [WIDTH-1:0]           tbl_val,
  input  logic [WIDTH-1:0]           tbl_mask,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       cfg_strict,
  input  logic [TMO_W-1:0]           cfg_tmo,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           io_in,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic                       tmo,
  output logic [$clog2(DEPTH):0]     step,
  output logic [WIDTH-1:0]           last_io
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_prev_q;
  logic [WIDTH-1:0] val_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];

  state_t           state_q,   state_d;
  logic [SW-1:0]    step_q,    step_d;
  logic [TMO_W-1:0] cnt_q,     cnt_d;
  logic [SW-1:0]    len_q,     len_d;
  logic             strict_q,  strict_d;
  logic [TMO_W-1:0] tmo_cfg_q, tmo_cfg_d;
  logic             busy_q,    busy_d;
  logic             pass_q,    pass_d;
  logic             fail_q,    fail_d;
  logic             tmo_q,     tmo_d;
  logic [WIDTH-1:0] last_io_q, last_io_d;

  logic [AW-1:0]    idx_cur, idx_prev;
  logic [SW-1:0]    len_eff;
  logic [TMO_W-1:0] cnt_inc;
  logic             match_cur, match_prev, s_changed, timeout_hit;

  io_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (io_in),
    .q   (s)
  );

  // Expected-value table is deliberately left out of reset so a reset
  // between runs keeps the programmed sequence.
  always_ff @(posedge wb_clk_i) begin
    if (tbl_we) begin
      val_q[tbl_addr]  <= tbl_val;
      mask_q[tbl_addr] <= tbl_mask;
    end
  end

  assign idx_cur    = step_q[AW-1:0];
  assign idx_prev   = idx_cur - AW'(1);
  assign match_cur  = ((s & mask_q[idx_cur]) == (val_q[idx_cur] & mask_q[idx_cur]));
  assign match_prev = (step_q != '0) &&
                      ((s & mask_q[idx_prev]) == (val_q[idx_prev] & mask_q[idx_prev]));
  assign s_changed  = (s != s_prev_q);
  assign cnt_inc    = sat_inc(cnt_q);
  assign timeout_hit = (tmo_cfg_q != '0) && (cnt_inc >= tmo_cfg_q);
  assign len_eff    = (cfg_len == '0)         ? SW'(1) :
                      (cfg_len > SW'(DEPTH))  ? SW'(DEPTH) : cfg_len;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    strict_d  = strict_q;
    tmo_cfg_d = tmo_cfg_q;
    busy_d    = busy_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    last_io_d = last_io_q;

    if (abort) begin
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else if (start) begin
      state_d   = ST_RUN;
      step_d    = '0;
      cnt_d     = '0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      tmo_d     = 1'b0;
      busy_d    = 1'b1;
      len_d     = len_eff;
      strict_d  = cfg_strict;
      tmo_cfg_d = cfg_tmo;
    end else if (state_q == ST_RUN) begin
      // Priority: match, then strict violation, then timeout.
      if (match_cur) begin
        step_d = step_q + SW'(1);
        cnt_d  = '0;
        if (step_q == len_q - SW'(1)) begin
          pass_d    = 1'b1;
          busy_d    = 1'b0;
          last_io_d = s;
          state_d   = ST_DONE;
        end
      end else if ((strict_q == MODE_STRICT) && s_changed && !match_prev) begin
        fail_d    = 1'b1;
        busy_d    = 1'b0;
        last_io_d = s;
        state_d   = ST_DONE;
      end else if (timeout_hit) begin
        fail_d    = 1'b1;
        tmo_d     = 1'b1;
        busy_d    = 1'b0;
        last_io_d = s;
        state_d   = ST_DONE;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      len_q     <= SW'(1);
      strict_q  <= MODE_ORDERED;
      tmo_cfg_q <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
      last_io_q <= '0;
      s_prev_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      strict_q  <= strict_d;
      tmo_cfg_q <= tmo_cfg_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      last_io_q <= last_io_d;
      s_prev_q  <= s;
    end
  end

  assign busy    = busy_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign tmo     = tmo_q;
  assign step    = step_q;
  assign last_io = last_io_q;

endmodule

// File: tb/tb_io_seq_checker.sv
// Directed self-checking bench for io_seq_checker (WIDTH=8, DEPTH=16).
module tb_io_seq_checker;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [7:0]  tbl_val;
  logic [7:0]  tbl_mask;
  logic [4:0]  cfg_len;
  logic        cfg_strict;
  logic [15:0] cfg_tmo;
  logic        start;
  logic        abort;
  logic [7:0]  io_in;
  logic        busy, pass, fail, tmo;
  logic [4:0]  step;
  logic [7:0]  last_io;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  io_seq_checker dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_val    (tbl_val),
    .tbl_mask   (tbl_mask),
    .cfg_len    (cfg_len),
    .cfg_strict (cfg_strict),
    .cfg_tmo    (cfg_tmo),
    .start      (start),
    .abort      (abort),
    .io_in      (io_in),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .tmo        (tmo),
    .step       (step),
    .last_io    (last_io)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic hold_io(input logic [7:0] v, input int n);
    io_in = v;
    tick(n);
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [7:0] v, input logic [7:0] m);
    tbl_we = 1'b1; tbl_addr = a; tbl_val = v; tbl_mask = m;
    tick(1);
    tbl_we = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic strict, input logic [15:0] t);
    cfg_len = len; cfg_strict = strict; cfg_tmo = t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL reset_fail: got %0b expected 0", fail); end
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL reset_tmo: got %0b expected 0", tmo); end
    n_checks++; if (step !== 5'd0) begin n_errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    n_checks++; if (last_io !== 8'h00) begin n_errors++; $display("FAIL reset_last_io: got %0h expected 0", last_io); end
  endtask

  task automatic test_ordered();
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ord_busy: got %0b expected 1", busy); end
    for (int i = 0; i < 12; i++) begin
      hold_io(8'h77, 2);
      hold_io(seq[i], 4);
      n_checks++;
      if (step !== 5'(i + 1)) begin
        n_errors++; $display("FAIL ord_step%0d: got %0d expected %0d", i, step, i + 1);
      end
    end
    n_checks++; if (pass !== 1'b1) begin n_errors++; $display("FAIL ord_pass: got %0b expected 1", pass); end
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL ord_fail: got %0b expected 0", fail); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ord_busy_end: got %0b expected 0", busy); end
    n_checks++; if (last_io !== 8'h00) begin n_errors++; $display("FAIL ord_last_io: got %0h expected 00", last_io); end
  endtask

  task automatic test_restart();
    // From DONE, start again: sticky flags clear; cfg_len=0 behaves as 1.
    hold_io(8'h00, 3);
    do_start(5'd0, 1'b0, 16'd0);
    n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL rst_pass_clr: got %0b expected 0", pass); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_busy: got %0b expected 1", busy); end
    n_checks++; if (step !== 5'd0) begin n_errors++; $display("FAIL rst_step0: got %0d expected 0", step); end
    hold_io(8'h01, 4);
    n_checks++; if (pass !== 1'b1) begin n_errors++; $display("FAIL len0_pass: got %0b expected 1", pass); end
    n_checks++; if (step !== 5'd1) begin n_errors++; $display("FAIL len0_step: got %0d expected 1", step); end
  endtask

  task automatic test_strict();
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b1, 16'd0);
    hold_io(8'h01, 4);
    hold_io(8'h02, 4);
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL str_nofail: got %0b expected 0", fail); end
    hold_io(8'h55, 4);
    n_checks++; if (fail !== 1'b1) begin n_errors++; $display("FAIL str_fail: got %0b expected 1", fail); end
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL str_tmo: got %0b expected 0", tmo); end
    n_checks++; if (step !== 5'd2) begin n_errors++; $display("FAIL str_step: got %0d expected 2", step); end
    n_checks++; if (last_io !== 8'h55) begin n_errors++; $display("FAIL str_last_io: got %0h expected 55", last_io); end
    n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL str_pass: got %0b expected 0", pass); end
  endtask

  task automatic test_timeout();
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd100);
    tick(99);
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL tmo_early: got %0b expected 0", fail); end
    tick(1);
    n_checks++; if (fail !== 1'b1) begin n_errors++; $display("FAIL tmo_fail: got %0b expected 1", fail); end
    n_checks++; if (tmo !== 1'b1) begin n_errors++; $display("FAIL tmo_flag: got %0b expected 1", tmo); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tmo_busy: got %0b expected 0", busy); end
    // Match arriving exactly on the 100th cycle beats the timeout.
    do_start(5'd12, 1'b0, 16'd100);
    tick(97);
    hold_io(8'h01, 2);
    n_checks++; if (step !== 5'd0) begin n_errors++; $display("FAIL tmo_edge_pre: got %0d expected 0", step); end
    tick(1);
    n_checks++; if (step !== 5'd1) begin n_errors++; $display("FAIL tmo_edge_step: got %0d expected 1", step); end
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL tmo_edge_fail: got %0b expected 0", fail); end
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL tmo_edge_tmo: got %0b expected 0", tmo); end
    do_abort();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_mask();
    write_entry(4'd0, 8'h03, 8'h0F);
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd0);
    hold_io(8'hA3, 4);
    n_checks++; if (step !== 5'd1) begin n_errors++; $display("FAIL mask_step: got %0d expected 1", step); end
    do_abort();
    write_entry(4'd0, 8'h01, 8'hFF);
  endtask

  task automatic test_reset_midrun();
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) hold_io(seq[i], 4);
    n_checks++; if (step !== 5'd5) begin n_errors++; $display("FAIL rm_step5: got %0d expected 5", step); end
    #2 wb_rst_i = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %0b expected 0", busy); end
    n_checks++; if (step !== 5'd0) begin n_errors++; $display("FAIL rm_step: got %0d expected 0", step); end
    n_checks++; if (pass !== 1'b0 || fail !== 1'b0) begin
      n_errors++; $display("FAIL rm_flags: got pass=%0b fail=%0b expected 0/0", pass, fail);
    end
    tick(1);
    wb_rst_i = 1'b0;
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd0);
    for (int i = 0; i < 12; i++) begin
      hold_io(8'h77, 2);
      hold_io(seq[i], 4);
    end
    n_checks++; if (pass !== 1'b1) begin n_errors++; $display("FAIL rm_rerun_pass: got %0b expected 1", pass); end
    n_checks++; if (step !== 5'd12) begin n_errors++; $display("FAIL rm_rerun_step: got %0d expected 12", step); end
  endtask

  task automatic test_start_abort();
    hold_io(8'h00, 3);
    do_start(5'd12, 1'b0, 16'd0);
    hold_io(8'h01, 4);
    n_checks++; if (step !== 5'd1) begin n_errors++; $display("FAIL sa_step1: got %0d expected 1", step); end
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sa_busy: got %0b expected 0", busy); end
    hold_io(8'h02, 4);
    n_checks++; if (step !== 5'd1) begin n_errors++; $display("FAIL sa_idle_step: got %0d expected 1", step); end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    tbl_we = 1'b0; tbl_addr = '0; tbl_val = '0; tbl_mask = '0;
    cfg_len = '0; cfg_strict = 1'b0; cfg_tmo = '0;
    start = 1'b0; abort = 1'b0; io_in = 8'h00;
    tick(2);
    test_reset();
    wb_rst_i = 1'b0;
    tick(1);
    for (int i = 0; i < 12; i++) write_entry(4'(i), seq[i], 8'hFF);
    test_ordered();
    test_restart();
    test_strict();
    test_timeout();
    test_mask();
    test_reset_midrun();
    test_start_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
